// File: rtl/step_pulse_gen_mc.sv
// Multi-channel step/direction pulse generator with per-channel pending-step queue.
// Define STEP_POS_COUNT_EN to add per-channel signed position counters (pos, pos_clr).
module step_pulse_gen_mc #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 16,
    parameter int Q_DEPTH = 2,
    parameter int POS_W   = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [N_CH*CNT_W-1:0]              pre_n,
    input  logic [N_CH*CNT_W-1:0]              pulse_n,
    input  logic [N_CH*CNT_W-1:0]              post_n,
    input  logic [N_CH-1:0]                    step_stb,
    input  logic [N_CH-1:0]                    step_dir,
    input  logic                               miss_clr,
`ifdef STEP_POS_COUNT_EN
    input  logic                               pos_clr,
    output logic [N_CH*POS_W-1:0]              pos,
`endif
    output logic [N_CH-1:0]                    step,
    output logic [N_CH-1:0]                    dir,
    output logic [N_CH-1:0]                    missed,
    output logic [N_CH-1:0]                    miss_sticky,
    output logic [N_CH-1:0]                    busy,
    output logic [N_CH*($clog2(Q_DEPTH)+1)-1:0] q_level
);

    localparam int QW = $clog2(Q_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, PRE, HIGH, POST} state_t;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t             state;
        logic [CNT_W-1:0]   cnt;
        logic [CNT_W-1:0]   pre_s;
        logic [CNT_W-1:0]   pul_s;
        logic [CNT_W-1:0]   post_s;
        logic [Q_DEPTH-1:0] q;
        logic [Q_DEPTH-1:0] q_nx;
        logic [QW-1:0]      qcnt;
        logic [QW-1:0]      wr;
        logic               step_r;
        logic               dir_r;
        logic               miss_r;
        logic               sticky_r;
        logic [CNT_W-1:0]   pre_i;
        logic [CNT_W-1:0]   pul_i;
        logic [CNT_W-1:0]   post_i;
        logic               stb;
        logic               done;
        logic               qv;
        logic               pop;
        logic               idle_go;
        logic               go;
        logic               go_dir;
        logic               full;
        logic               push;
        logic               miss;

        assign stb    = step_stb[i];
        assign pre_i  = pre_n[i*CNT_W +: CNT_W];
        assign post_i = post_n[i*CNT_W +: CNT_W];
        assign pul_i  = (pulse_n[i*CNT_W +: CNT_W] == '0) ? CNT_W'(1)
                                                          : pulse_n[i*CNT_W +: CNT_W];

        // done marks the edge the step sequence ends; a queued step starts on that same edge
        assign done    = (state == HIGH && cnt == pul_s && post_s == '0) ||
                         (state == POST && cnt == post_s);
        assign qv      = (qcnt != '0);
        assign pop     = qv && (done || state == IDLE);
        assign idle_go = (state == IDLE) && !qv && stb;
        assign go      = pop || idle_go;
        assign go_dir  = pop ? q[0] : step_dir[i];
        assign full    = (qcnt == QW'(Q_DEPTH));
        assign push    = stb && !idle_go && (!full || pop);
        assign miss    = stb && !idle_go && full && !pop;
        assign wr      = qcnt - QW'(pop);

        always_comb begin
            q_nx = pop ? (q >> 1) : q;
            for (int k = 0; k < Q_DEPTH; k++) begin
                if (push && wr == QW'(k)) q_nx[k] = step_dir[i];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state    <= IDLE;
                cnt      <= '0;
                pre_s    <= '0;
                pul_s    <= '0;
                post_s   <= '0;
                q        <= '0;
                qcnt     <= '0;
                step_r   <= 1'b0;
                dir_r    <= 1'b0;
                miss_r   <= 1'b0;
                sticky_r <= 1'b0;
            end else begin
                q      <= q_nx;
                qcnt   <= qcnt + QW'(push) - QW'(pop);
                miss_r <= miss;
                if (miss)          sticky_r <= 1'b1;
                else if (miss_clr) sticky_r <= 1'b0;

                if (go) begin
                    dir_r  <= go_dir;
                    pre_s  <= pre_i;
                    pul_s  <= pul_i;
                    post_s <= post_i;
                    cnt    <= CNT_W'(1);
                    if (pre_i == '0) begin
                        state  <= HIGH;
                        step_r <= 1'b1;
                    end else begin
                        state  <= PRE;
                        step_r <= 1'b0;
                    end
                end else begin
                    case (state)
                        PRE: begin
                            if (cnt == pre_s) begin
                                state  <= HIGH;
                                step_r <= 1'b1;
                                cnt    <= CNT_W'(1);
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                        HIGH: begin
                            if (cnt == pul_s) begin
                                step_r <= 1'b0;
                                cnt    <= CNT_W'(1);
                                state  <= (post_s == '0) ? IDLE : POST;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                        POST: begin
                            if (cnt == post_s) state <= IDLE;
                            else               cnt   <= cnt + CNT_W'(1);
                        end
                        default: ;
                    endcase
                end
            end
        end

        assign step[i]               = step_r;
        assign dir[i]                = dir_r;
        assign missed[i]             = miss_r;
        assign miss_sticky[i]        = sticky_r;
        assign busy[i]               = (state != IDLE);
        assign q_level[i*QW +: QW]   = qcnt;

`ifdef STEP_POS_COUNT_EN
        logic [POS_W-1:0] pos_r;
        logic             rise;
        logic             rise_dir;

        assign rise     = go ? (pre_i == '0) : (state == PRE && cnt == pre_s);
        assign rise_dir = go ? go_dir : dir_r;

        always_ff @(posedge clk or posedge reset) begin
            if (reset)        pos_r <= '0;
            else if (pos_clr) pos_r <= '0;
            else if (rise)    pos_r <= rise_dir ? pos_r + POS_W'(1) : pos_r - POS_W'(1);
        end

        assign pos[i*POS_W +: POS_W] = pos_r;
`endif
    end

endmodule
